// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings, LSU FSM states and byte-enable helpers.
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } lsu_state_t;

  // Half accesses only honour addr[1]; word accesses ignore both low bits.
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = BE_BYTE << off;
      SIZE_HALF: be = BE_HALF << {off[1], 1'b0};
      default:   be = BE_WORD;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load lane select plus sign/zero extension (module load_extend).
module load_extend
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata_i[{byte_off_i, 3'b000} +: 8];
    lane_h = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{lane_b[7]}}, lane_b};
      F3_LH:   data_o = {{16{lane_h[15]}}, lane_h};
      F3_LBU:  data_o = {24'h000000, lane_b};
      F3_LHU:  data_o = {16'h0000, lane_h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one req/ready bus transaction per access, stalls M meanwhile.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses raise MisalignM instead of using the bus.
module mem_access_unit
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        Funct3M,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  output logic [31:0]       ReadDataM,
  output logic              StallM,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ready,
`ifdef MISALIGN_TRAP_EN
  output logic              MisalignM,
`endif
  input  logic [31:0]       bus_rdata
);

  lsu_state_t        state_q, state_d;
  logic              mem_op, start;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [31:0]       bus_wdata_q, wdata_d, rdata_q, load_data;
  logic [3:0]        bus_be_q;
  logic              bus_we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;

  assign mem_op = MemReadM | MemWriteM;

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  always_comb begin
    misalign = 1'b0;
    case (Funct3M[1:0])
      SIZE_BYTE: misalign = 1'b0;
      SIZE_HALF: misalign = ALUResultM[0];
      default:   misalign = |ALUResultM[1:0];
    endcase
  end
  // Gated by rst so the combinational outputs read 0 while reset is held.
  assign start     = rst & mem_op & ~misalign;
  assign MisalignM = rst & (state_q == IDLE) & mem_op & misalign;
`else
  assign start = rst & mem_op;
`endif

  always_comb begin
    case (Funct3M[1:0])
      SIZE_BYTE: wdata_d = {4{WriteDataM[7:0]}};
      SIZE_HALF: wdata_d = {2{WriteDataM[15:0]}};
      default:   wdata_d = WriteDataM;
    endcase
  end

  always_comb begin
    state_d = state_q;
    StallM  = 1'b0;
    bus_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          StallM  = 1'b1;
        end
      end
      REQ: begin
        StallM  = 1'b1;
        bus_req = 1'b1;
        if (bus_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane selection uses the latched offset and funct3, not the live M-stage inputs.
  load_extend u_load_extend (
    .funct3_i   (f3_q),
    .byte_off_i (off_q),
    .rdata_i    (bus_rdata),
    .data_o     (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      bus_we_q    <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        bus_addr_q  <= ADDR_W'({ALUResultM[31:2], 2'b00});
        bus_wdata_q <= wdata_d;
        bus_be_q    <= byte_enables(Funct3M[1:0], ALUResultM[1:0]);
        bus_we_q    <= MemWriteM;
        f3_q        <= Funct3M;
        off_q       <= ALUResultM[1:0];
      end
      if (state_q == REQ && bus_ready && !bus_we_q) rdata_q <= load_data;
    end
  end

  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;
  assign bus_we    = bus_we_q;
  assign ReadDataM = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; expected values are hand-computed per access.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        StallM, bus_req, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
`ifdef MISALIGN_TRAP_EN
  logic        MisalignM;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_ready  (bus_ready),
`ifdef MISALIGN_TRAP_EN
    .MisalignM  (MisalignM),
`endif
    .bus_rdata  (bus_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Captured results of the last access.
  int          acc_total, acc_stalls;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we, cap_stable, done_req, done_stall, acc_fin;

  // Entered and left at posedge+1; inputs stay applied until the caller changes them.
  task automatic do_access(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input int waits,
                           input logic [31:0] rdata);
    int rc;
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    acc_total = 0; acc_stalls = 0; rc = 0; acc_fin = 1'b0; cap_stable = 1'b1;
    done_req = 1'b1; done_stall = 1'b1;
    cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
    while (!acc_fin && acc_total < 30) begin
      if (bus_req) begin
        if (rc == 0) begin
          cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be; cap_we = bus_we;
        end else if (bus_addr !== cap_addr || bus_wdata !== cap_wdata || bus_be !== cap_be
                     || bus_we !== cap_we) begin
          cap_stable = 1'b0;
        end
        if (rc == waits) begin
          bus_ready = 1'b1;
          bus_rdata = rdata;
        end
        rc++;
      end
      @(negedge clk);
      acc_total++;
      if (StallM) acc_stalls++;
      if (bus_ready) begin
        @(posedge clk); #1;
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        @(negedge clk);
        acc_total++;
        done_req   = bus_req;
        done_stall = StallM;
        acc_fin    = 1'b1;
      end
      @(posedge clk); #1;
    end
    check_eq({name, " completed"}, {31'd0, acc_fin}, 32'd1);
    $display("%s addr=%h we=%0d be=%b wdata=%h cycles=%0d stalls=%0d rdata=%h",
             name, cap_addr, cap_we, cap_be, cap_wdata, acc_total, acc_stalls, ReadDataM);
  endtask

  task automatic idle_cycle(input string name);
    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
    ALUResultM = 32'h0000_0000; WriteDataM = 32'h0;
    @(negedge clk);
    check_eq({name, " StallM"}, {31'd0, StallM}, 32'd0);
    check_eq({name, " bus_req"}, {31'd0, bus_req}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
    ALUResultM = 32'h0; WriteDataM = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst bus_req",   {31'd0, bus_req}, 32'd0);
    check_eq("rst bus_we",    {31'd0, bus_we},  32'd0);
    check_eq("rst bus_addr",  bus_addr,  32'h0);
    check_eq("rst bus_wdata", bus_wdata, 32'h0);
    check_eq("rst bus_be",    {28'd0, bus_be}, 32'h0);
    check_eq("rst ReadDataM", ReadDataM, 32'h0);
    check_eq("rst StallM",    {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    idle_cycle("nop");

    do_access("LW", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    check_eq("LW addr",      cap_addr, 32'h100);
    check_eq("LW be",        {28'd0, cap_be}, 32'hF);
    check_eq("LW we",        {31'd0, cap_we}, 32'd0);
    check_eq("LW stalls",    acc_stalls, 4);
    check_eq("LW cycles",    acc_total, 5);
    check_eq("LW stable",    {31'd0, cap_stable}, 32'd1);
    check_eq("LW done stall", {31'd0, done_stall}, 32'd0);
    check_eq("LW ReadDataM", ReadDataM, 32'hDEADBEEF);
    idle_cycle("nop");

    do_access("LB", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80000000);
    check_eq("LB be",        {28'd0, cap_be}, 32'h8);
    check_eq("LB addr",      cap_addr, 32'h100);
    check_eq("LB ReadDataM", ReadDataM, 32'hFFFFFF80);
    do_access("LBU", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80000000);
    check_eq("LBU ReadDataM", ReadDataM, 32'h00000080);
    check_eq("LBU cycles",    acc_total, 4);
    idle_cycle("nop");

    do_access("SH", 1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 1, 32'hFFFFFFFF);
    check_eq("SH we",        {31'd0, cap_we}, 32'd1);
    check_eq("SH be",        {28'd0, cap_be}, 32'hC);
    check_eq("SH wdata",     cap_wdata, 32'hABCDABCD);
    check_eq("SH addr",      cap_addr, 32'h100);
    check_eq("SH ReadDataM", ReadDataM, 32'h00000080);
    idle_cycle("nop");

    do_access("SB", 1'b0, 1'b1, 3'b000, 32'h205, 32'h000000A5, 0, 32'h0);
    check_eq("SB cycles",   acc_total, 3);
    check_eq("SB be",       {28'd0, cap_be}, 32'h2);
    check_eq("SB wdata",    cap_wdata, 32'hA5A5A5A5);
    check_eq("SB done req", {31'd0, done_req}, 32'd0);
    do_access("LW2", 1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 0, 32'h11223344);
    check_eq("LW2 cycles",    acc_total, 3);
    check_eq("LW2 addr",      cap_addr, 32'h204);
    check_eq("LW2 ReadDataM", ReadDataM, 32'h11223344);

    do_access("LH", 1'b1, 1'b0, 3'b001, 32'h106, 32'h0, 0, 32'h80017FFF);
    check_eq("LH be",        {28'd0, cap_be}, 32'hC);
    check_eq("LH ReadDataM", ReadDataM, 32'hFFFF8001);
    do_access("LHU", 1'b1, 1'b0, 3'b101, 32'h104, 32'h0, 0, 32'h80017FFF);
    check_eq("LHU be",        {28'd0, cap_be}, 32'h3);
    check_eq("LHU ReadDataM", ReadDataM, 32'h00007FFF);
    idle_cycle("nop");

`ifdef MISALIGN_TRAP_EN
    MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h101;
    @(negedge clk);
    check_eq("MIS MisalignM", {31'd0, MisalignM}, 32'd1);
    check_eq("MIS StallM",    {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;
    check_eq("MIS bus_req",   {31'd0, bus_req}, 32'd0);
    check_eq("MIS ReadDataM", ReadDataM, 32'h00007FFF);
    idle_cycle("nop");
`else
    do_access("LWmis", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'hCAFEF00D);
    check_eq("LWmis addr",      cap_addr, 32'h100);
    check_eq("LWmis be",        {28'd0, cap_be}, 32'hF);
    check_eq("LWmis ReadDataM", ReadDataM, 32'hCAFEF00D);
    do_access("LHmis", 1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 0, 32'h9ABC1234);
    check_eq("LHmis be",        {28'd0, cap_be}, 32'hC);
    check_eq("LHmis ReadDataM", ReadDataM, 32'hFFFF9ABC);
    idle_cycle("nop");
`endif

    // Reset while a request is outstanding.
    MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h300;
    @(posedge clk); #1;
    check_eq("RST reached REQ", {31'd0, bus_req}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("RST bus_req",  {31'd0, bus_req}, 32'd0);
    check_eq("RST StallM",   {31'd0, StallM}, 32'd0);
    check_eq("RST ReadDataM", ReadDataM, 32'h0);
    @(posedge clk); #1;
    MemReadM = 1'b0;
    rst = 1'b1;
    idle_cycle("post-rst");
    do_access("LWr", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1, 32'h0BADF00D);
    check_eq("LWr cycles",    acc_total, 4);
    check_eq("LWr ReadDataM", ReadDataM, 32'h0BADF00D);
    idle_cycle("nop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
